mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the IITB-RISC pipeline, directly upstream of write-back.
//  Accepts one EX-stage op at a time: ALU pass-through, load or store. Loads and stores go through a
//  req/ack data-memory port. Produces the registered 38-bit WB bundle consumed by write-back.
//  Stalls EX (in_ready low) while a memory access is outstanding.
// PARAMETERS
//  DW          16   data/address width
//  TIMEOUT     15   max cycles waiting for mem_ack before abort (>=1)
// PORTS
//  clk            in   1    single clock, rising edge
//  resetn         in   1    asynchronous, active-low reset
//  in_valid       in   1    EX op valid
//  in_ready       out  1    stage can accept op this cycle
//  in_op          in   2    00 ALU pass, 01 load, 10 store, 11 treated as ALU pass
//  in_wb_en       in   1    op writes the register file
//  in_rd          in   3    destination register
//  in_result      in   DW   ALU result (ALU pass) / effective address (load, store)
//  in_sdata       in   DW   store data
//  in_pc          in   DW   PC of op
//  flush          in   1    squash current/in-flight op (branch redirect)
//  mem_req        out  1    memory request, held until mem_ack
//  mem_we         out  1    1 = write
//  mem_addr       out  DW   address
//  mem_wdata      out  DW   write data
//  mem_rdata      in   DW   read data, valid with mem_ack
//  mem_ack        in   1    one-cycle completion
//  wb_valid       out  1    wb_data valid this cycle (one-cycle pulse)
//  wb_data        out  38   [0] wb_en, [1] is_load, [4:2] rd, [20:5] data, [36:21] pc, [37] valid
//  mem_err        out  1    sticky: timeout occurred; cleared only by reset
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE; all outputs 0 except in_ready=1. Timeout counter = 0.
//  FSM IDLE:
//   - in_ready=1.
//   - Accept occurs when in_valid & !flush.
//   - ALU op: next cycle wb_valid=1 with wb_data = {1,pc,result,rd,0,wb_en}. Stay IDLE (1 op/cycle).
//   - Load/store: latch addr/data/rd/pc/wb_en. Go to MEM_WAIT; mem_req=1 from the next cycle.
//  FSM MEM_WAIT:
//   - in_ready=0; mem_req/mem_we/mem_addr/mem_wdata are stable until ack.
//   - On mem_ack: mem_req drops the same edge. Go to IDLE. Next cycle wb_valid=1:
//     - load: data=mem_rdata, [1]=1, [0]=wb_en.
//     - store: [0]=0, [1]=0, data=sdata.
//   - Counter increments each waiting cycle. At TIMEOUT without ack: drop mem_req, set mem_err,
//     return to IDLE, emit no wb_valid.
//  Latency: ALU 1 cycle; mem op = 1 + ack-wait + 1.
//  flush:
//   - In IDLE, flush blocks acceptance and suppresses a wb_valid due next cycle.
//   - In MEM_WAIT, the memory request is not cancelled; wait for ack (or timeout). Set a kill flag
//     so the resulting wb_valid is suppressed. The kill flag clears on return to IDLE.
//  Simultaneous events:
//   - mem_ack together with flush: op completes, no wb_valid.
//   - mem_ack in the same cycle as the counter reaches TIMEOUT: ack wins, no error.
//   - in_valid during MEM_WAIT is ignored (in_ready=0); EX must hold.
//  When wb_valid=0, wb_data = 0 (bit 37 clear).
//  Reset mid-access: everything clears immediately, mem_req falls asynchronously.
//  Counter width: $clog2(TIMEOUT+1); it never wraps.
// STRUCTURE
//  Shared package iitb_pkg:
//   - OP_ALU/OP_LOAD/OP_STORE encodings
//   - WB bundle field offsets (WB_EN=0, WB_LD=1, WB_RD=4:2, WB_DATA=20:5, WB_PC=36:21, WB_V=37)
//   - state enum IDLE/MEM_WAIT
//  Single optional sub-module mem_req_timer (counter + expiry); everything else is flat.
// TESTING
//  1 ALU ops: 3 back-to-back (rd=1..3, results 0x0011,0x0022,0x0033) -> wb_valid 3 consecutive
//    cycles, matching data, [1]=0, in_ready stays 1.
//  2 Load: addr 0x0040, ack after 3 cycles with rdata 0xBEEF, rd=5 -> mem_req high 3 cycles,
//    in_ready low; then wb_data[20:5]=0xBEEF, [4:2]=5, [1:0]=2'b11.
//  3 Store: addr 0x0010, sdata 0x1234, immediate ack -> mem_we=1, mem_wdata=0x1234;
//    wb_valid=1 with [0]=0.
//  4 Flush during MEM_WAIT of a load -> mem_req held until ack, no wb_valid; next ALU op
//    accepted and written back normally.
//  5 Timeout: no ack, TIMEOUT=15 -> mem_req drops after 15 wait cycles, mem_err=1 sticky,
//    no wb_valid, in_ready=1. A second variant with ack on cycle 15 -> completes, mem_err=0.
//  6 resetn asserted mid MEM_WAIT -> mem_req, wb_valid, mem_err go 0 immediately;
//    in_ready=1 after release.

Source files
------------

// File: rtl/iitb_pkg.sv
// Shared IITB-RISC definitions: op encodings, write-back bundle layout and MEM-stage states.
package iitb_pkg;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam int WB_W        = 38;
  localparam int WB_EN       = 0;
  localparam int WB_LD       = 1;
  localparam int WB_RD_LSB   = 2;
  localparam int WB_RD_MSB   = 4;
  localparam int WB_DATA_LSB = 5;
  localparam int WB_DATA_MSB = 20;
  localparam int WB_PC_LSB   = 21;
  localparam int WB_PC_MSB   = 36;
  localparam int WB_V        = 37;

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_e;

  function automatic logic [WB_W-1:0] pack_wb(input logic wb_en, input logic is_load,
                                               input logic [2:0] rd, input logic [15:0] data,
                                               input logic [15:0] pc);
    logic [WB_W-1:0] w;
    w = '0;
    w[WB_EN] = wb_en;
    w[WB_LD] = is_load;
    w[WB_RD_MSB:WB_RD_LSB] = rd;
    w[WB_DATA_MSB:WB_DATA_LSB] = data;
    w[WB_PC_MSB:WB_PC_LSB] = pc;
    w[WB_V] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Counts cycles spent waiting on the data-memory ack and flags expiry on the TIMEOUT-th wait cycle.
module mem_req_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates at TIMEOUT so it can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// IITB-RISC MEM stage: ALU pass-through, loads and stores over a req/ack port,
// producing the registered write-back bundle.
module mem_access_stage
  import iitb_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_wb_en,
  input  logic [2:0]      in_rd,
  input  logic [DW-1:0]   in_result,
  input  logic [DW-1:0]   in_sdata,
  input  logic [DW-1:0]   in_pc,
  input  logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            wb_valid,
  output logic [WB_W-1:0] wb_data,
  output logic            mem_err
);

  state_e          state_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [DW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [2:0]      rd_q;
  logic [DW-1:0]   pc_q;
  logic            wb_en_q;
  logic            is_load_q;
  logic            kill_q;
  logic            err_q;
  logic            wb_valid_q;
  logic [WB_W-1:0] wb_data_q;

  logic timer_run;
  logic timer_expire;
  logic is_mem_op;

  assign is_mem_op = (in_op == OP_LOAD) || (in_op == OP_STORE);
  assign timer_run = (state_q == MEM_WAIT) && !mem_ack;

  mem_req_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .run_i    (timer_run),
    .expire_o (timer_expire)
  );

  // A flushed access still runs to ack/timeout on the bus; kill_q only hides its write-back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      wb_en_q     <= 1'b0;
      is_load_q   <= 1'b0;
      kill_q      <= 1'b0;
      err_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      case (state_q)
        IDLE: begin
          if (in_valid && !flush) begin
            if (is_mem_op) begin
              state_q     <= MEM_WAIT;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (in_op == OP_STORE);
              mem_addr_q  <= in_result;
              mem_wdata_q <= in_sdata;
              rd_q        <= in_rd;
              pc_q        <= in_pc;
              wb_en_q     <= in_wb_en;
              is_load_q   <= (in_op == OP_LOAD);
              kill_q      <= 1'b0;
            end else begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= pack_wb(in_wb_en, 1'b0, in_rd, in_result, in_pc);
            end
          end
        end
        MEM_WAIT: begin
          if (flush) begin
            kill_q <= 1'b1;
          end
          if (mem_ack || timer_expire) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            kill_q      <= 1'b0;
          end
          // Ack takes priority over a coincident expiry.
          if (mem_ack) begin
            if (!kill_q && !flush) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= is_load_q ? pack_wb(wb_en_q, 1'b1, rd_q, mem_rdata, pc_q)
                                      : pack_wb(1'b0, 1'b0, rd_q, mem_wdata_q, pc_q);
            end
          end else if (timer_expire) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: transaction-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_access_stage;

  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [1:0]    inOp = '0;
  logic          inWbEn = 1'b0;
  logic [2:0]    inRd = '0;
  logic [DW-1:0] inResult = '0;
  logic [DW-1:0] inSdata = '0;
  logic [DW-1:0] inPc = '0;
  logic          flush = 1'b0;
  logic          memReq;
  logic          memWe;
  logic [DW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata = '0;
  logic          memAck = 1'b0;
  logic          wbValid;
  logic [37:0]   wbData;
  logic          memErr;

  int errCount = 0;
  int checkCount = 0;

  mem_access_stage #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_op     (inOp),
    .in_wb_en  (inWbEn),
    .in_rd     (inRd),
    .in_result (inResult),
    .in_sdata  (inSdata),
    .in_pc     (inPc),
    .flush     (flush),
    .mem_req   (memReq),
    .mem_we    (memWe),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata),
    .mem_ack   (memAck),
    .wb_valid  (wbValid),
    .wb_data   (wbData),
    .mem_err   (memErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [37:0] bundle(input logic en, input logic ld, input logic [2:0] rd,
                                         input logic [15:0] data, input logic [15:0] pc);
    return {1'b1, pc, data, rd, ld, en};
  endfunction

  // Reference model: one outstanding op, tracked as a transaction with an elapsed-wait count.
  bit          mBusy = 0;
  bit          mKill = 0;
  bit          mErr = 0;
  bit          mLoad = 0;
  bit          mWe = 0;
  bit          mWbEn = 0;
  logic [2:0]  mRd = '0;
  logic [15:0] mAddr = '0;
  logic [15:0] mSdata = '0;
  logic [15:0] mPc = '0;
  int          mWait = 0;
  logic        expValid = 1'b0;
  logic [37:0] expData = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mBusy = 0; mKill = 0; mErr = 0; mWait = 0;
      expValid = 1'b0; expData = '0;
    end else begin
      expValid = 1'b0;
      expData = '0;
      if (!mBusy) begin
        if (inValid && !flush) begin
          if (inOp == 2'b01 || inOp == 2'b10) begin
            mBusy = 1; mKill = 0; mWait = 0;
            mLoad = (inOp == 2'b01); mWe = (inOp == 2'b10);
            mWbEn = inWbEn; mRd = inRd; mAddr = inResult; mSdata = inSdata; mPc = inPc;
          end else begin
            expValid = 1'b1;
            expData = bundle(inWbEn, 1'b0, inRd, inResult, inPc);
          end
        end
      end else begin
        mWait++;
        if (flush) mKill = 1;
        if (memAck) begin
          mBusy = 0;
          if (!mKill) begin
            expValid = 1'b1;
            expData = mLoad ? bundle(mWbEn, 1'b1, mRd, memRdata, mPc)
                            : bundle(1'b0, 1'b0, mRd, mSdata, mPc);
          end
        end else if (mWait >= TIMEOUT) begin
          mBusy = 0;
          mErr = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      checkOutput("cmp in_ready", inReady, !mBusy);
      checkOutput("cmp mem_req", memReq, mBusy);
      checkOutput("cmp mem_err", memErr, mErr);
      checkOutput("cmp wb_valid", wbValid, expValid);
      checkOutput("cmp wb_data", wbData, expData);
      if (mBusy) begin
        checkOutput("cmp mem_we", memWe, mWe);
        checkOutput("cmp mem_addr", memAddr, mAddr);
        checkOutput("cmp mem_wdata", memWdata, mSdata);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic en, input logic [2:0] rd,
                               input logic [15:0] res, input logic [15:0] sd, input logic [15:0] pc);
    inValid = v; inOp = op; inWbEn = en; inRd = rd; inResult = res; inSdata = sd; inPc = pc;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
  endtask

  logic [15:0] aluRes [3] = '{16'h0011, 16'h0022, 16'h0033};
  logic [1:0]  aluOp  [3] = '{2'b00, 2'b00, 2'b11};
  logic        aluEn  [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    tick();
    checkOutput("reset in_ready", inReady, 1);
    checkOutput("reset mem_req", memReq, 0);
    checkOutput("reset wb_valid", wbValid, 0);
    checkOutput("reset wb_data", wbData, 0);
    checkOutput("reset mem_err", memErr, 0);
    #2 resetn = 1'b1;
    tick();

    // Back-to-back ALU ops, including op 11 treated as ALU.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, aluOp[i], aluEn[i], 3'(i + 1), aluRes[i], 16'h0, 16'(16'h0100 + i));
      tick();
      checkOutput("alu wb_valid", wbValid, 1);
      checkOutput("alu data", wbData[20:5], aluRes[i]);
      checkOutput("alu rd", wbData[4:2], i + 1);
      checkOutput("alu is_load", wbData[1], 0);
      checkOutput("alu in_ready", inReady, 1);
    end
    idle();
    tick();
    checkOutput("alu drained", wbValid, 0);

    // Load with ack in the third wait cycle.
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd5, 16'h0040, 16'h0, 16'h0200);
    tick();
    idle();
    checkOutput("load mem_addr", memAddr, 16'h0040);
    checkOutput("load mem_we", memWe, 0);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("load mem_req", memReq, 1);
      checkOutput("load in_ready", inReady, 0);
      if (k == 3) begin
        memAck = 1'b1;
        memRdata = 16'hBEEF;
      end
      tick();
    end
    memAck = 1'b0;
    memRdata = '0;
    checkOutput("load req dropped", memReq, 0);
    checkOutput("load wb_valid", wbValid, 1);
    checkOutput("load data", wbData[20:5], 16'hBEEF);
    checkOutput("load rd", wbData[4:2], 5);
    checkOutput("load flags", wbData[1:0], 2'b11);

    // Store with immediate ack.
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010, 16'h1234, 16'h0300);
    tick();
    idle();
    checkOutput("store mem_we", memWe, 1);
    checkOutput("store mem_wdata", memWdata, 16'h1234);
    checkOutput("store mem_addr", memAddr, 16'h0010);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    checkOutput("store wb_valid", wbValid, 1);
    checkOutput("store wb_en", wbData[0], 0);
    checkOutput("store is_load", wbData[1], 0);
    checkOutput("store data", wbData[20:5], 16'h1234);

    // Flush in IDLE blocks acceptance.
    applyStimulus(1'b1, 2'b00, 1'b1, 3'd4, 16'h0044, 16'h0, 16'h0400);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    checkOutput("idle flush wb_valid", wbValid, 0);

    // Flush during MEM_WAIT: request held to ack, write-back suppressed.
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd6, 16'h0050, 16'h0, 16'h0500);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush mem_req held", memReq, 1);
    tick();
    memAck = 1'b1;
    memRdata = 16'hAAAA;
    tick();
    memAck = 1'b0;
    memRdata = '0;
    checkOutput("flush wb_valid", wbValid, 0);
    checkOutput("flush mem_req", memReq, 0);
    applyStimulus(1'b1, 2'b00, 1'b1, 3'd7, 16'h0077, 16'h0, 16'h0600);
    tick();
    idle();
    checkOutput("post flush wb_valid", wbValid, 1);
    checkOutput("post flush data", wbData[20:5], 16'h0077);

    // Ack coinciding with flush.
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd3, 16'h0058, 16'h0, 16'h0580);
    tick();
    idle();
    memAck = 1'b1;
    flush = 1'b1;
    tick();
    memAck = 1'b0;
    flush = 1'b0;
    checkOutput("ack+flush wb_valid", wbValid, 0);

    // Timeout with no ack.
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd1, 16'h0060, 16'h0, 16'h0700);
    tick();
    idle();
    for (int k = 1; k <= TIMEOUT; k++) begin
      checkOutput("timeout mem_req", memReq, 1);
      tick();
    end
    checkOutput("timeout req dropped", memReq, 0);
    checkOutput("timeout mem_err", memErr, 1);
    checkOutput("timeout wb_valid", wbValid, 0);
    checkOutput("timeout in_ready", inReady, 1);
    tick();
    checkOutput("mem_err sticky", memErr, 1);

    // Reset mid-access clears everything asynchronously.
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd2, 16'h0070, 16'h0, 16'h0780);
    tick();
    idle();
    tick();
    #2 resetn = 1'b0;
    #1;
    checkOutput("async rst mem_req", memReq, 0);
    checkOutput("async rst wb_valid", wbValid, 0);
    checkOutput("async rst mem_err", memErr, 0);
    tick();
    #2 resetn = 1'b1;
    tick();
    checkOutput("post rst in_ready", inReady, 1);

    // Ack on the final wait cycle wins over expiry.
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd2, 16'h0080, 16'h0, 16'h0800);
    tick();
    idle();
    for (int k = 1; k <= TIMEOUT; k++) begin
      checkOutput("late ack mem_req", memReq, 1);
      if (k == TIMEOUT) begin
        memAck = 1'b1;
        memRdata = 16'h5555;
      end
      tick();
    end
    memAck = 1'b0;
    memRdata = '0;
    checkOutput("late ack wb_valid", wbValid, 1);
    checkOutput("late ack mem_err", memErr, 0);
    checkOutput("late ack data", wbData[20:5], 16'h5555);
    tick();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
